// File: rtl/watch_pkg.sv
// Shared definitions for the watch front-end: mode encoding, key polarity
// and the per-key release event record.
package watch_pkg;

    localparam int NUM_KEYS  = 2;
    localparam int NUM_MODES = 4;

    localparam logic [1:0] MODE_VIEW      = 2'd0;
    localparam logic [1:0] MODE_STOPWATCH = 2'd1;
    localparam logic [1:0] MODE_TIMER     = 2'd2;
    localparam logic [1:0] MODE_ALARM     = 2'd3;

    // Buttons pull low when pressed.
    localparam logic KEY_PRESSED = 1'b0;

    // Classification of one release: at most one field set per cycle.
    typedef struct packed {
        logic short_p;
        logic long_p;
    } key_evt_t;

    // Advance the mode, wrapping at num_modes.
    function automatic logic [1:0] next_mode(input logic [1:0] m, input int num_modes);
        if (int'(m) >= num_modes - 1)
            return 2'd0;
        return m + 2'd1;
    endfunction

endpackage

// File: rtl/mode_key_ctrl_key_debounce.sv
// One push-button channel: 2-flop synchroniser, debounce counter,
// saturating hold counter and short/long release classifier.
module key_debounce
    import watch_pkg::*;
#(
    parameter int DB_CYCLES   = 500_000,
    parameter int LONG_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_db,
    output logic short_pulse,
    output logic long_pulse,
    output logic long_held
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HW  = $clog2(LONG_CYCLES + 1);

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(LONG_CYCLES);

    logic           sync_q1_q, sync_q1_d;
    logic           sync_q2_q, sync_q2_d;
    logic           db_q, db_d;
    logic           db_prev_q, db_prev_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0]  hold_q, hold_d;
    key_evt_t       evt_q, evt_d;

    // Synchroniser: the raw button is asynchronous to the clock.
    always_comb begin
        sync_q1_d = key_raw;
        sync_q2_d = sync_q1_q;
    end

    // Debounce: a level change is accepted only after DB_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync_q2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d     = sync_q2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end
    end

    // Hold counter: counts pressed cycles and sticks at LONG_CYCLES.
    always_comb begin
        hold_d = hold_q;
        if (db_q != KEY_PRESSED)
            hold_d = '0;
        else if (hold_q != HOLD_MAX)
            hold_d = hold_q + HW'(1);
    end

    // Classifier: one registered pulse the cycle after the debounced level
    // rises; hold_q still holds the press length because it clears on this
    // same edge.
    always_comb begin
        db_prev_d     = db_q;
        evt_d.short_p = db_q && !db_prev_q && (hold_q <  HOLD_MAX);
        evt_d.long_p  = db_q && !db_prev_q && (hold_q >= HOLD_MAX);
    end

    // State registers; released/idle polarity on reset so no spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1_q <= 1'b1;
            sync_q2_q <= 1'b1;
            db_q      <= 1'b1;
            db_prev_q <= 1'b1;
            db_cnt_q  <= '0;
            hold_q    <= '0;
            evt_q     <= '0;
        end else begin
            sync_q1_q <= sync_q1_d;
            sync_q2_q <= sync_q2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            db_cnt_q  <= db_cnt_d;
            hold_q    <= hold_d;
            evt_q     <= evt_d;
        end
    end

    // Outputs straight from flops, long_held decoded from the hold count.
    always_comb begin
        key_db      = db_q;
        short_pulse = evt_q.short_p;
        long_pulse  = evt_q.long_p;
        long_held   = (db_q == KEY_PRESSED) && (hold_q == HOLD_MAX);
    end

endmodule

// File: rtl/mode_key_ctrl.sv
// Push-button front-end: per-key debounce/classify channels, the mode
// register advanced by a long KEY0 press, and per-mode gated key buses.
module mode_key_ctrl #(
    parameter int DB_CYCLES   = 500_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int NUM_MODES   = watch_pkg::NUM_MODES
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [1:0]             KEY,
    output logic [1:0]             key_db,
    output logic [1:0]             short_pulse,
    output logic [1:0]             long_pulse,
    output logic [1:0]             long_held,
    output logic [1:0]             mode,
    output logic                   mode_chg,
    output logic [2*NUM_MODES-1:0] mode_keys
);

    import watch_pkg::*;

    // mode is 2 bits wide, so more than four modes cannot be encoded.
    if (NUM_MODES > 4 || NUM_MODES < 1) begin : g_bad_num_modes
        $error("mode_key_ctrl: NUM_MODES must be in 1..4");
    end

    logic [1:0] mode_q, mode_d;
    logic       mode_chg_q, mode_chg_d;
    logic [1:0] key_gated;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DB_CYCLES  (DB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES)
        ) u_key (
            .clk        (CLOCK_50),
            .rst        (reset),
            .key_raw    (KEY[k]),
            .key_db     (key_db[k]),
            .short_pulse(short_pulse[k]),
            .long_pulse (long_pulse[k]),
            .long_held  (long_held[k])
        );
    end

    // Next mode: only a long KEY0 release advances; KEY1 never touches mode.
    always_comb begin
        mode_d     = mode_q;
        mode_chg_d = 1'b0;
        if (long_pulse[0]) begin
            mode_d     = next_mode(mode_q, NUM_MODES);
            mode_chg_d = 1'b1;
        end
    end

    // Mode register and its change strobe update on the same edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_VIEW;
            mode_chg_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            mode_chg_q <= mode_chg_d;
        end
    end

    // Key bus seen by the active submodule: a mode-switch hold on KEY0 is
    // hidden once it has become long, so the submodule never acts on it.
    always_comb begin
        key_gated = {key_db[1], key_db[0] | long_held[0]};
    end

    // Route the gated keys into the active mode's slot; idle slots read released.
    always_comb begin
        mode_keys = '1;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (mode_q == 2'(m))
                mode_keys[2*m +: 2] = key_gated;
        end
    end

    // Registered mode state to the ports.
    always_comb begin
        mode     = mode_q;
        mode_chg = mode_chg_q;
    end

endmodule

// File: tb/tb_mode_key_ctrl.sv
// Bench for mode_key_ctrl with DB_CYCLES=4, LONG_CYCLES=20. Stimulus pushes
// expected release/mode events into a queue; a monitor pops one per event.
module tb_mode_key_ctrl;

    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int NM   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  KEY;
    logic [1:0]  key_db, short_pulse, long_pulse, long_held, mode;
    logic        mode_chg;
    logic [7:0]  mode_keys;

    typedef struct packed {
        logic [1:0] sp;
        logic [1:0] lp;
        logic       mc;
        logic [1:0] md;
    } ev_t;

    ev_t        exp_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [1:0] exp_mode = 2'd0;

    always #5 clk = ~clk;

    mode_key_ctrl #(
        .DB_CYCLES  (DB),
        .LONG_CYCLES(LONG),
        .NUM_MODES  (NM)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .KEY        (KEY),
        .key_db     (key_db),
        .short_pulse(short_pulse),
        .long_pulse (long_pulse),
        .long_held  (long_held),
        .mode       (mode),
        .mode_chg   (mode_chg),
        .mode_keys  (mode_keys)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Monitor: every cycle with a pulse or mode change consumes one expectation.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (!rst && (short_pulse != 2'b00 || long_pulse != 2'b00 || mode_chg)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'({short_pulse, long_pulse, mode_chg, mode}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event", 32'({short_pulse, long_pulse, mode_chg, mode}), 32'(e));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_key_db"},    32'(key_db),      32'h3);
        check({tag, "_mode"},      32'(mode),        32'h0);
        check({tag, "_pulses"},    32'({short_pulse, long_pulse, mode_chg}), 32'h0);
        check({tag, "_long_held"}, 32'(long_held),   32'h0);
        check({tag, "_mode_keys"}, 32'(mode_keys),   32'hFF);
    endtask

    // Expect a release with the given classification, then verify its timing:
    // key_db rises 6 cycles after the raw release, pulse 1 cycle later,
    // mode_chg 1 cycle after that for a long KEY0.
    task automatic release_and_check(input logic [1:0] sp_e, input logic [1:0] lp_e);
        ev_t e;
        e.sp = sp_e; e.lp = lp_e; e.mc = 1'b0; e.md = exp_mode;
        exp_q.push_back(e);
        if (lp_e[0]) begin
            exp_mode = (exp_mode == 2'(NM - 1)) ? 2'd0 : exp_mode + 2'd1;
            e.sp = 2'b00; e.lp = 2'b00; e.mc = 1'b1; e.md = exp_mode;
            exp_q.push_back(e);
        end
        KEY = 2'b11;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("release_db_high", 32'(key_db), 32'h3);
        check("release_no_pulse_yet", 32'({short_pulse, long_pulse}), 32'h0);
        @(posedge clk); @(negedge clk);
        check("release_pulse", 32'({short_pulse, long_pulse}), 32'({sp_e, lp_e}));
        @(posedge clk); @(negedge clk);
        check("release_mode_chg", 32'({short_pulse, long_pulse, mode_chg}), 32'(lp_e[0]));
        check("release_mode", 32'(mode), 32'(exp_mode));
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    // Hold key i for ni raw cycles (0 = untouched), both releasing together.
    // At loop cycle chk_at, mode_keys and long_held are compared.
    task automatic press(input int n0, input int n1, input int chk_at,
                         input logic [7:0] exp_mk, input logic [1:0] exp_lh);
        int mx;
        logic [1:0] sp_e, lp_e;
        mx = (n0 > n1) ? n0 : n1;
        for (int c = 0; c < mx; c++) begin
            KEY[0] = (c >= mx - n0) ? 1'b0 : 1'b1;
            KEY[1] = (c >= mx - n1) ? 1'b0 : 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (c == chk_at) begin
                check("held_mode_keys", 32'(mode_keys), 32'(exp_mk));
                check("held_long_held", 32'(long_held), 32'(exp_lh));
            end
        end
        sp_e = {(n1 > 0 && n1 < LONG), (n0 > 0 && n0 < LONG)};
        lp_e = {(n1 >= LONG), (n0 >= LONG)};
        release_and_check(sp_e, lp_e);
    endtask

    initial begin : stim
        int bounce_bad;
        rst = 1'b1;
        KEY = 2'b11;

        // 1: reset values, then reset asserted mid-run with KEY0 pressed
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        KEY = 2'b10;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t1_db_low", 32'(key_db), 32'h2);
        rst = 1'b1;
        #1;
        check_reset_state("mid_reset");
        KEY = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_mode = 2'd0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t1_idle_db", 32'(key_db), 32'h3);

        // 2: bounce of 2-cycle runs never gets through, final edge lands after 6
        bounce_bad = 0;
        for (int i = 0; i < 6; i++) begin
            KEY[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) begin
                @(posedge clk); @(negedge clk);
                if (key_db != 2'b11) bounce_bad++;
            end
        end
        check("t2_bounce_filtered", 32'(bounce_bad), 32'd0);
        KEY[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t2_db_before_6", 32'(key_db), 32'h3);
        @(posedge clk); @(negedge clk);
        check("t2_db_at_6", 32'(key_db), 32'h2);
        repeat (10) @(posedge clk);
        @(negedge clk);
        release_and_check(2'b01, 2'b00);

        // 3: short presses, including one cycle below the long threshold
        press(10, 0, 5,  8'hFE, 2'b00);
        press(19, 0, 18, 8'hFE, 2'b00);
        check("t3_mode_view", 32'(mode), 32'h0);

        // 4: long presses walk the mode 0->1->2->3->0
        press(30, 0, 29, 8'hFF, 2'b01);
        press(30, 0, 24, 8'hFB, 2'b00);
        press(20, 0, 19, 8'hEF, 2'b00);
        press(25, 0, 24, 8'hBF, 2'b00);
        check("t4_mode_wrapped", 32'(mode), 32'h0);

        // 5: reset at hold count 15, key kept down across reset release
        KEY = 2'b10;
        repeat (21) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_reset_state("t5_reset");
        @(negedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_mode = 2'd0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t5_db_before_6", 32'(key_db), 32'h3);
        @(posedge clk); @(negedge clk);
        check("t5_db_at_6", 32'(key_db), 32'h2);
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("t5_hold_19", 32'(long_held), 32'h0);
        @(posedge clk); @(negedge clk);
        check("t5_hold_20", 32'(long_held), 32'h1);
        release_and_check(2'b00, 2'b01);

        // 6: reach mode 2, then long KEY0 + short KEY1 released together
        press(30, 0, -1, 8'h00, 2'b00);
        check("t6_mode_timer", 32'(mode), 32'h2);
        press(28, 8, 27, 8'hDF, 2'b01);
        check("t6_mode_alarm", 32'(mode), 32'h3);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("events_all_seen", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
